// File: rtl/debounce_sync.sv
// Push-button conditioner: 2-flop synchroniser followed by a counter-qualified
// level filter producing a clean level plus single-cycle rise/fall strobes.
module debounce_sync #(
   parameter int unsigned STABLE_CYCLES = 10,
   parameter int unsigned CNT_W         = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din_raw,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      IDLE_HIGH,
      WAIT_LOW
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         dout_q  <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         s1_q    <= din_raw;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Any reversion of s2 while qualifying drops back to idle with cnt cleared.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (s2_q) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!s2_q) begin
               state_d = IDLE_LOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               dout_d  = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s2_q) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (s2_q) begin
               state_d = IDLE_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               dout_d  = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
         end
      endcase
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance (10 cycles) and a 2-cycle override,
// each checked every cycle against a run-length reference model.
module tb_debounce_sync;

   localparam int STAB_A = 10;
   localparam int STAB_B = 2;

   logic clk;
   logic rst;
   logic din_a, din_b;
   logic dout_a, rise_a, fall_a, busy_a;
   logic dout_b, rise_b, fall_b, busy_b;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 0;

   debounce_sync dut_a (
      .clk(clk), .rst(rst), .din_raw(din_a),
      .dout(dout_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
   );

   debounce_sync #(.STABLE_CYCLES(STAB_B), .CNT_W(1)) dut_b (
      .clk(clk), .rst(rst), .din_raw(din_b),
      .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: input seen two edges late; the level flips once it has
   // disagreed with the output for STAB consecutive edges.
   bit m_s1[2], m_s2[2], m_dout[2], m_rise[2], m_fall[2];
   int m_run[2];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_dout[i] = 0;
            m_rise[i] = 0; m_fall[i] = 0; m_run[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (m_s2[i] != m_dout[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == ((i == 0) ? STAB_A : STAB_B)) begin
                  m_run[i]  = 0;
                  m_dout[i] = m_s2[i];
                  m_rise[i] = m_s2[i];
                  m_fall[i] = !m_s2[i];
               end
            end else begin
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = (i == 0) ? din_a : din_b;
         end
      end
   end

   bit prev_rise_a, prev_fall_a, prev_rise_b, prev_fall_b;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("dout_a", dout_a, m_dout[0]);
         chk("rise_a", rise_a, m_rise[0]);
         chk("fall_a", fall_a, m_fall[0]);
         chk("busy_a", busy_a, m_run[0] != 0);
         chk("dout_b", dout_b, m_dout[1]);
         chk("rise_b", rise_b, m_rise[1]);
         chk("fall_b", fall_b, m_fall[1]);
         chk("busy_b", busy_b, m_run[1] != 0);
         chk("rise_fall_excl_a", rise_a & fall_a, 0);
         chk("rise_fall_excl_b", rise_b & fall_b, 0);
         chk("rise_single_a", rise_a & prev_rise_a, 0);
         chk("fall_single_a", fall_a & prev_fall_a, 0);
         chk("rise_single_b", rise_b & prev_rise_b, 0);
         chk("fall_single_b", fall_b & prev_fall_b, 0);
      end
      prev_rise_a = rise_a; prev_fall_a = fall_a;
      prev_rise_b = rise_b; prev_fall_b = fall_b;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      int len;
      int exp_rises;
      int exp_high;
   } pulse_t;

   pulse_t ptab[6];
   int nr, nf, nh, re, hold_a, hold_b;

   initial begin
      ptab[0] = '{len: 1,  exp_rises: 0, exp_high: 0};
      ptab[1] = '{len: 5,  exp_rises: 0, exp_high: 0};
      ptab[2] = '{len: 9,  exp_rises: 0, exp_high: 0};
      ptab[3] = '{len: 10, exp_rises: 1, exp_high: 10};
      ptab[4] = '{len: 11, exp_rises: 1, exp_high: 11};
      ptab[5] = '{len: 16, exp_rises: 1, exp_high: 16};

      rst = 1'b0; din_a = 1'b0; din_b = 1'b0;
      chk_on = 1;

      // Held in reset with a toggling input
      for (int n = 0; n < 12; n++) begin
         if (n % 3 == 0) begin din_a = !din_a; din_b = !din_b; end
         step();
         chk("rst_dout", dout_a, 0); chk("rst_rise", rise_a, 0);
         chk("rst_fall", fall_a, 0); chk("rst_busy", busy_a, 0);
         chk("rst_dout_b", dout_b, 0);
      end
      din_a = 1'b0; din_b = 1'b0;
      rst = 1'b1;
      repeat (20) step();

      // Clean rise
      din_a = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         step();
         chk("clean_rise_busy", busy_a, (n >= 3 && n <= 11));
         chk("clean_rise_dout", dout_a, (n >= 12));
         chk("clean_rise_strobe", rise_a, (n == 12));
      end

      // Clean fall
      din_a = 1'b0;
      for (int n = 1; n <= 13; n++) begin
         step();
         chk("clean_fall_busy", busy_a, (n >= 3 && n <= 11));
         chk("clean_fall_dout", dout_a, (n < 12));
         chk("clean_fall_strobe", fall_a, (n == 12));
      end
      repeat (5) step();

      // Bounce: 4 high, 2 low, then steady high
      nr = 0; re = -1;
      din_a = 1'b1;
      repeat (4) begin step(); nr += rise_a; end
      din_a = 1'b0;
      repeat (2) begin step(); nr += rise_a; end
      din_a = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (rise_a) begin nr++; re = n; end
      end
      chk("bounce_rise_count", nr, 1);
      chk("bounce_rise_edge", re, STAB_A + 2);

      // Asynchronous reset mid-cycle while high, input held high through release
      chk("pre_reset_dout", dout_a, 1);
      #1 rst = 1'b0;
      #1;
      chk("async_rst_dout", dout_a, 0);
      chk("async_rst_busy", busy_a, 0);
      repeat (3) step();
      rst = 1'b1;
      re = -1; nr = 0;
      for (int n = 1; n <= 16; n++) begin
         step();
         if (rise_a) begin nr++; re = n; end
      end
      chk("release_rise_count", nr, 1);
      chk("release_rise_edge", re, STAB_A + 2);
      din_a = 1'b0;
      repeat (20) step();

      // Pulse-length table
      for (int t = 0; t < 6; t++) begin
         nr = 0; nf = 0; nh = 0;
         din_a = 1'b1;
         repeat (ptab[t].len) begin step(); nr += rise_a; nf += fall_a; nh += dout_a; end
         din_a = 1'b0;
         repeat (30) begin step(); nr += rise_a; nf += fall_a; nh += dout_a; end
         chk($sformatf("pulse%0d_rises", ptab[t].len), nr, ptab[t].exp_rises);
         chk($sformatf("pulse%0d_falls", ptab[t].len), nf, ptab[t].exp_rises);
         chk($sformatf("pulse%0d_high", ptab[t].len), nh, ptab[t].exp_high);
      end

      // Override instance: commit at edge 4, 1-cycle glitch rejected
      din_b = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         step();
         chk("b_rise_dout", dout_b, (n >= 4));
         chk("b_rise_strobe", rise_b, (n == 4));
      end
      din_b = 1'b0;
      step();
      chk("b_glitch_dout0", dout_b, 1);
      din_b = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         step();
         chk("b_glitch_dout", dout_b, 1);
         chk("b_glitch_fall", fall_b, 0);
      end
      din_b = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         step();
         chk("b_fall_dout", dout_b, (n < 4));
         chk("b_fall_strobe", fall_b, (n == 4));
      end

      // Randomised run-length stimulus with occasional async resets
      hold_a = 0; hold_b = 0;
      for (int n = 0; n < 4000; n++) begin
         if (hold_a == 0) begin din_a = !din_a; hold_a = $urandom_range(1, 14); end
         if (hold_b == 0) begin din_b = !din_b; hold_b = $urandom_range(1, 4); end
         hold_a--; hold_b--;
         if ($urandom_range(0, 499) == 0) begin
            #1 rst = 1'b0;
            #1 rst = 1'b1;
         end
         step();
      end

      chk_on = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
